// File: rtl/img_pkg.sv
// Shared image geometry, RGB field layout, luma weights and frame-sequencer
// state encoding for the grayscale conversion path.
package img_pkg;

  localparam int IMG_WIDTH  = 220;
  localparam int IMG_HEIGHT = 220;
  localparam int N_PIXELS   = IMG_WIDTH * IMG_HEIGHT;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // Weights total 256, so luma is simply the top byte of the weighted sum.
  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/rgb2gray_pixel.sv
// One RGB word in, registered 8-bit luma out; the enable lets a caller
// freeze the result (pause), and the block is shared with the live-video path.
module rgb2gray_pixel
  import img_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] rgb,
  output logic [7:0]  gray
);

  logic [15:0] sum;

  // The 16-bit sum peaks at 65280, so truncating to the top byte never overflows.
  assign sum = COEF_R * {8'd0, rgb[R_MSB:R_LSB]}
             + COEF_G * {8'd0, rgb[G_MSB:G_LSB]}
             + COEF_B * {8'd0, rgb[B_MSB:B_LSB]};

  always_ff @(posedge clock) begin
    if (reset) begin
      gray <= '0;
    end else if (en) begin
      gray <= sum[15:8];
    end
  end

endmodule

// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer: streams every RGB pixel out of the source BRAM, converts it
// to gray and writes it to the destination BRAM, one pixel per unpaused cycle.
module rgb2gray_frame_ctrl
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = img_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = img_pkg::IMG_HEIGHT,
  parameter int ADDR_BITS  = 16,
  parameter int RGB_WIDTH  = 24,
  parameter int GRAY_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  output logic                  src_en,
  output logic [ADDR_BITS-1:0]  src_addr,
  input  logic [RGB_WIDTH-1:0]  src_rdata,
  output logic                  dst_en,
  output logic                  dst_we,
  output logic [ADDR_BITS-1:0]  dst_addr,
  output logic [GRAY_WIDTH-1:0] dst_wdata
);

  localparam int N = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);

  state_t               state;
  logic                 src_act;
  logic                 b_valid;
  logic [ADDR_BITS-1:0] b_addr;
  logic                 c_valid;

  // Pause and reset drop the BRAM strobes in the same cycle so a borrowed or
  // aborted frame never sees a stray access.
  assign src_en = src_act & ~pause & ~reset;
  assign dst_en = c_valid & ~pause & ~reset;
  assign dst_we = dst_en;

  rgb2gray_pixel u_pixel (
    .clock (clock),
    .reset (reset),
    .en    (b_valid & ~pause),
    .rgb   (src_rdata),
    .gray  (dst_wdata)
  );

  // Stage A issues the read, stage B sees BRAM data, stage C writes gray.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_act  <= 1'b0;
      src_addr <= '0;
      b_valid  <= 1'b0;
      b_addr   <= '0;
      c_valid  <= 1'b0;
      dst_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            src_act  <= 1'b1;
            src_addr <= '0;
          end
        end
        RUN, DRAIN: begin
          if (!pause) begin
            b_valid  <= src_act;
            b_addr   <= src_addr;
            c_valid  <= b_valid;
            dst_addr <= b_addr;
            if (state == RUN) begin
              if (src_addr == LAST_ADDR) begin
                src_act <= 1'b0;
                state   <= DRAIN;
              end else begin
                src_addr <= src_addr + ADDR_BITS'(1);
              end
            end else if (!b_valid) begin
              // Stage C is doing the final write this cycle.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
